// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding fetch to instruction
// memory and feeds the registered IF/ID boundary, squashing wrong-path fetches on redirect.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] IF_pc_out,
    output logic [31:0] IF_instr_out,
    output logic        IF_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } ifid_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] hold_buf_q, hold_buf_d;
    ifid_t           ifid_q, ifid_d;
    logic            im_req_q, im_req_d;

    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] seq_pc;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign seq_pc       = req_addr_q + PC_STEP;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            hold_buf_q <= '0;
            ifid_q     <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            im_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
            ifid_q     <= ifid_d;
            im_req_q   <= im_req_d;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        hold_buf_d = hold_buf_q;
        ifid_d     = ifid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    req_addr_d = redirect_tgt;
                end else begin
                    req_addr_d = pc_q;
                end
            end

            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    // A request still in flight must complete before the new target is issued
                    if (im_rvalid) begin
                        req_addr_d = redirect_tgt;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (im_rvalid) begin
                    if (!stall) begin
                        ifid_d     = '{pc: req_addr_q, instr: im_rdata, valid: 1'b1};
                        pc_d       = seq_pc;
                        req_addr_d = seq_pc;
                    end else begin
                        hold_buf_d = im_rdata;
                        state_d    = S_HOLD;
                    end
                end else if (!stall) begin
                    ifid_d.instr = NOP_INSTR;
                    ifid_d.valid = 1'b0;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    req_addr_d = redirect_tgt;
                    hold_buf_d = '0;
                    state_d    = S_WAIT;
                end else if (!stall) begin
                    ifid_d     = '{pc: req_addr_q, instr: hold_buf_q, valid: 1'b1};
                    pc_d       = seq_pc;
                    req_addr_d = seq_pc;
                    state_d    = S_WAIT;
                end
            end

            S_DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (im_rvalid) begin
                    req_addr_d = redirect_valid ? redirect_tgt : pc_q;
                    state_d    = S_WAIT;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Redirect squashes whatever sits at IF/ID, stall or not
        if (redirect_valid) begin
            ifid_d.instr = NOP_INSTR;
            ifid_d.valid = 1'b0;
        end

        im_req_d = (state_d == S_WAIT) || (state_d == S_DROP);
    end

    assign im_req       = im_req_q;
    assign im_addr      = req_addr_q;
    assign IF_pc_out    = ifid_q.pc;
    assign IF_instr_out = ifid_q.instr;
    assign IF_valid     = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: variable-latency memory, directed scenarios, then random
// stall/redirect traffic checked against an in-order instruction-stream reference.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_rvalid;
    logic [31:0] im_rdata;
    logic [31:0] IF_pc_out;
    logic [31:0] IF_instr_out;
    logic        IF_valid;

    // Second instance with a reset PC at the top of the address space, zero-latency memory
    logic        stall2 = 1'b0;
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic        im_req2;
    logic [31:0] im_addr2;
    logic        im_rvalid2;
    logic [31:0] im_rdata2;
    logic [31:0] pc2, instr2;
    logic        valid2;

    assign im_rvalid2 = im_req2;
    assign im_rdata2  = im_addr2 ^ KEY;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .IF_pc_out(IF_pc_out), .IF_instr_out(IF_instr_out), .IF_valid(IF_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .im_req(im_req2), .im_addr(im_addr2), .im_rvalid(im_rvalid2), .im_rdata(im_rdata2),
        .IF_pc_out(pc2), .IF_instr_out(instr2), .IF_valid(valid2)
    );

    int checks = 0;
    int errors = 0;

    // Memory responder state
    bit pending = 1'b0;
    int cnt = 0;
    int lat_cur = 0;
    int lat_cfg = 0;
    bit late_pulse = 1'b0;

    // Reference: next PC decode must see, in program order
    logic [31:0] exp_pc = 32'h0;
    int gap = 0;
    int consumed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: memory drives at negedge, reference model and invariants checked after posedge
    task automatic tick();
        logic        p_req, p_rv, p_valid, p_stall, p_redir;
        logic [31:0] p_addr, p_pc, p_instr, p_tgt;
        @(negedge clk);
        im_rdata = $urandom();
        if (late_pulse) begin
            im_rvalid = 1'b1;
            im_rdata  = 32'hDEAD_BEEF;
        end else if (im_req) begin
            if (!pending) begin
                pending = 1'b1;
                cnt     = 0;
                lat_cur = (lat_cfg < 0) ? int'($urandom_range(3, 0)) : lat_cfg;
            end
            if (cnt >= lat_cur) begin
                im_rvalid = 1'b1;
                im_rdata  = im_addr ^ KEY;
                pending   = 1'b0;
            end else begin
                im_rvalid = 1'b0;
                cnt++;
            end
        end else begin
            im_rvalid = 1'b0;
            pending   = 1'b0;
        end
        p_req = im_req;     p_rv = im_rvalid;     p_addr = im_addr;
        p_valid = IF_valid; p_pc = IF_pc_out;     p_instr = IF_instr_out;
        p_stall = stall;    p_redir = redirect_valid; p_tgt = redirect_pc;
        @(posedge clk);
        #1;
        if (p_valid && !p_stall && !p_redir) begin
            chk("consume_pc", p_pc, exp_pc);
            chk("consume_instr", p_instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            consumed++;
            gap = 0;
        end else begin
            gap++;
        end
        if (p_redir) begin
            exp_pc = p_tgt & ~32'h3;
            chk("redirect_squash_valid", 32'(IF_valid), 32'd0);
            chk("redirect_squash_instr", IF_instr_out, NOP);
        end
        if (!IF_valid) chk("bubble_is_nop", IF_instr_out, NOP);
        if (p_req && !p_rv) begin
            chk("req_not_withdrawn", 32'(im_req), 32'd1);
            chk("addr_stable", im_addr, p_addr);
        end
        if (gap > 200) begin
            chk("progress_timeout", 32'(gap), 32'd0);
            gap = 0;
        end
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        im_rvalid = 1'b0; im_rdata = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_instr", IF_instr_out, NOP);
        chk("rst_valid", 32'(IF_valid), 32'd0);
        chk("rst_pc", IF_pc_out, 32'h0);
        rst = 1'b1;

        // IDLE cycle then first request; zero-latency streaming
        lat_cfg = 0;
        tick();
        chk("first_req", 32'(im_req), 32'd1);
        chk("first_addr", im_addr, 32'h0);
        chk("wrap_first_addr", im_addr2, 32'hFFFF_FFFC);
        tick();
        chk("s0_pc", IF_pc_out, 32'h0);
        chk("s0_instr", IF_instr_out, 32'h0 ^ KEY);
        chk("s0_valid", 32'(IF_valid), 32'd1);
        chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
        chk("wrap_instr0", instr2, 32'hFFFF_FFFC ^ KEY);
        chk("wrap_next_addr", im_addr2, 32'h0);
        tick();
        chk("s1_pc", IF_pc_out, 32'h4);
        chk("wrap_pc1", pc2, 32'h0);
        chk("wrap_valid1", 32'(valid2), 32'd1);
        tick();
        chk("s2_pc", IF_pc_out, 32'h8);
        chk("s2_instr", IF_instr_out, 32'h8 ^ KEY);

        // Latency 3 (two waiting cycles) gives two bubbles before 0xC
        lat_cfg = 2;
        tick();
        chk("lat_bubble1_valid", 32'(IF_valid), 32'd0);
        chk("lat_bubble1_pc_held", IF_pc_out, 32'h8);
        tick();
        chk("lat_bubble2_valid", 32'(IF_valid), 32'd0);
        tick();
        chk("lat_pc", IF_pc_out, 32'hC);
        chk("lat_valid", 32'(IF_valid), 32'd1);

        // Stall across the response for 0x10: outputs frozen, request dropped in HOLD
        lat_cfg = 1;
        stall = 1'b1;
        tick();
        chk("stall_pc_frozen", IF_pc_out, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_pc_frozen", IF_pc_out, 32'hC);
            chk("hold_valid", 32'(IF_valid), 32'd1);
            chk("hold_no_req", 32'(im_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc", IF_pc_out, 32'h10);
        chk("unstall_instr", IF_instr_out, 32'h10 ^ KEY);
        chk("unstall_next_addr", im_addr, 32'h14);
        chk("unstall_req", 32'(im_req), 32'd1);

        // Redirect while 0x14 still outstanding
        lat_cfg = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("drop_valid", 32'(IF_valid), 32'd0);
        chk("drop_addr_held", im_addr, 32'h14);
        tick();
        chk("drop_addr_held2", im_addr, 32'h14);
        tick();
        chk("drop_new_addr", im_addr, 32'h100);
        chk("drop_still_bubble", 32'(IF_valid), 32'd0);
        lat_cfg = 0;
        tick();
        chk("redir_pc", IF_pc_out, 32'h100);
        chk("redir_instr", IF_instr_out, 32'h100 ^ KEY);

        // Redirect coincident with response; low target bits ignored
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        chk("coinc_addr", im_addr, 32'h200);
        chk("coinc_valid", 32'(IF_valid), 32'd0);
        tick();
        chk("coinc_pc", IF_pc_out, 32'h200);
        chk("coinc_instr", IF_instr_out, 32'h200 ^ KEY);

        // Reset mid-request, then a late response while IDLE
        lat_cfg = 3;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_req", 32'(im_req), 32'd0);
        chk("midrst_instr", IF_instr_out, NOP);
        chk("midrst_valid", 32'(IF_valid), 32'd0);
        chk("midrst_pc", IF_pc_out, 32'h0);
        pending = 1'b0; exp_pc = 32'h0; gap = 0;
        #10;
        rst = 1'b1;
        late_pulse = 1'b1;
        tick();
        late_pulse = 1'b0;
        chk("late_ignored_valid", 32'(IF_valid), 32'd0);
        chk("late_req_addr", im_addr, 32'h0);
        chk("late_req", 32'(im_req), 32'd1);
        lat_cfg = 0;
        tick();
        chk("after_rst_pc", IF_pc_out, 32'h0);
        chk("after_rst_instr", IF_instr_out, KEY);

        // Random latency, stalls and redirects against the in-order reference
        lat_cfg = -1;
        consumed = 0;
        for (int n = 0; n < 3000; n++) begin
            stall          = ($urandom_range(99, 0) < 30);
            redirect_valid = ($urandom_range(99, 0) < 6);
            redirect_pc    = $urandom();
            tick();
        end
        stall = 1'b0; redirect_valid = 1'b0;
        repeat (8) tick();
        chk("random_progress", 32'(consumed > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
